// File: rtl/hmmm_divider.sv
// hmmm_divider: multi-cycle signed restoring divide/modulo unit with defined divide-by-zero result
module hmmm_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] quo, dvs, q_fix, r_fix;
  logic [WIDTH:0] rem;
  logic [WIDTH+1:0] sh;
  logic accept, ge, neg_q, neg_r, op_r;
  assign accept = start && (state == IDLE || state == DONE);
  assign sh = {rem, quo[WIDTH-1]};
  assign ge = sh >= {2'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign busy = state == RUN || state == FIX;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = accept ? (divisor == '0 ? DONE : RUN)
            : state == RUN ? (cnt == '0 ? FIX : RUN)
            : state == FIX ? DONE
            : state == DONE ? IDLE : state;
  end
  // magnitudes are unsigned so the most negative operand keeps its full value
  always_ff @(posedge clk) begin
    if (!reset) begin
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r        <= op_mod;
      neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r       <= dividend[WIDTH-1];
      quo         <= dividend[WIDTH-1] ? -dividend : dividend;
      dvs         <= divisor[WIDTH-1] ? -divisor : divisor;
      rem         <= '0;
      cnt         <= CW'(WIDTH - 1);
      div_by_zero <= divisor == '0;
      if (divisor == '0) result <= '0;
    end else if (state == RUN) begin
      rem <= ge ? sh[WIDTH:0] - {1'b0, dvs} : sh[WIDTH:0];
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      result <= op_r ? r_fix : q_fix;
    end
  end
endmodule

// File: tb/tb_hmmm_divider.sv
// tb_hmmm_divider: table, corner-sequence and random checks of hmmm_divider against an arithmetic model
module tb_hmmm_divider;
  logic clk = 0, reset = 0, start = 0, op_mod = 0;
  logic [15:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [15:0] result;
  int n_vec = 0, n_bad = 0;

  hmmm_divider #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op_mod(op_mod),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic        dbz;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [15:0] a, b, input logic op, input logic [15:0] res, input logic dbz);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.dbz = dbz;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // signed truncating division in plain integer arithmetic; returns {div_by_zero, result}
  function automatic logic [16:0] model(input logic [15:0] a, b, input logic op);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {1'b1, 16'h0};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 16'(op ? r : q)};
  endfunction

  // launch in the current cycle (cycle 0) and follow it until done or a bound expires
  task automatic run_op(input logic [15:0] a, b, input logic op,
                        output int done_cyc, output int busy_cnt, output int busy_last,
                        output logic [15:0] res, output logic dbz, output logic bad_seq);
    logic [15:0] old;
    old = result;
    start = 1; dividend = a; divisor = b; op_mod = op;
    done_cyc = -1; busy_cnt = 0; busy_last = -1; bad_seq = 0; res = 'x; dbz = 'x;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      tick();
      start = 0;
      dividend = 16'($urandom);
      divisor = 16'($urandom);
      op_mod = 1'($urandom);
      if (busy && done) bad_seq = 1;
      if (busy) begin
        busy_cnt++;
        busy_last = c;
        if (result != old) bad_seq = 1;
      end
      if (done) begin
        done_cyc = c;
        res = result;
        dbz = div_by_zero;
      end
    end
  endtask

  initial begin
    int dc, bc, bl, dcyc;
    logic [15:0] r;
    logic z, bs, saw_done;
    logic [16:0] m;

    add(16'd100, 16'd7, 0, 16'h000E, 0);
    add(16'd100, 16'd7, 1, 16'h0002, 0);
    add(16'hFFF9, 16'd2, 0, 16'hFFFD, 0);
    add(16'hFFF9, 16'd2, 1, 16'hFFFF, 0);
    add(16'd7, 16'hFFFE, 1, 16'h0001, 0);
    add(16'hFFF8, 16'hFFFE, 0, 16'h0004, 0);
    add(16'h8000, 16'hFFFF, 0, 16'h8000, 0);
    add(16'h8000, 16'h0003, 1, 16'hFFFE, 0);
    add(16'd0, 16'd5, 0, 16'h0000, 0);
    add(16'd123, 16'd0, 0, 16'h0000, 1);
    add(16'd9, 16'd3, 0, 16'h0003, 0);

    reset = 0; start = 1; dividend = 16'd50; divisor = 16'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      chk("reset_dbz", div_by_zero, 0);
    end
    reset = 1; start = 0;
    tick();
    chk("idle_after_reset", {busy, done}, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, dc, bc, bl, r, z, bs);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_dbz", i), z, vecs[i].dbz);
      chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].dbz ? 1 : 18);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].dbz ? 0 : 17);
      chk($sformatf("vec%0d_busy_last", i), bl, vecs[i].dbz ? -1 : 17);
      chk($sformatf("vec%0d_sequence", i), bs, 0);
    end
    tick();
    chk("done_one_cycle", done, 0);

    // start while busy is ignored
    start = 1; dividend = 16'd1000; divisor = 16'd10; op_mod = 0;
    dcyc = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = (c == 5);
      if (c == 5) begin dividend = 16'd5; divisor = 16'd1; op_mod = 1; end
      if (done && dcyc < 0) begin
        dcyc = c;
        chk("ignore_result", result, 16'd100);
      end
    end
    chk("ignore_done_cycle", dcyc, 18);

    // reset mid-run aborts without a done pulse
    start = 1; dividend = 16'd1000; divisor = 16'd10; op_mod = 0;
    saw_done = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = (c == 5);
      reset = (c != 9);
      if (c == 5) begin dividend = 16'd5; divisor = 16'd1; end
      if (done) saw_done = 1;
      if (c == 10) chk("abort_busy", busy, 0);
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_result", result, 0);
    chk("abort_dbz", div_by_zero, 0);

    for (int i = 0; i < 200; i++) begin
      logic [15:0] a, b;
      logic op;
      a = 16'($urandom);
      b = 16'($urandom);
      op = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 9));
        3: a = 16'h8000;
        default: ;
      endcase
      m = model(a, b, op);
      run_op(a, b, op, dc, bc, bl, r, z, bs);
      chk($sformatf("rnd%0d_%h_%h_%0d", i, a, b, op), {z, r}, m);
      chk($sformatf("rnd%0d_latency", i), dc, m[16] ? 1 : 18);
      if (bs) chk($sformatf("rnd%0d_sequence", i), bs, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
